// File: rtl/ram_single_port.sv
// Single-port RAM with per-lane write strobes and a 0..4 stage stallable read pipeline.
// Define RAM_WRITE_FIRST_EN for write-first read-during-write; the default build is read-first.
module ram_single_port #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 64,
  parameter int BYTE_WIDTH   = 8,
  parameter     MEM_TYPE     = "auto",
  parameter int READ_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] strobe,
  input  logic [DATA_WIDTH-1:0]            wdata,
  output logic [DATA_WIDTH-1:0]            rdata
);

  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int NUM_LANES = DATA_WIDTH / BYTE_WIDTH;

  // Vendor spelling differs only for block RAM.
  localparam string RAM_STYLE = (MEM_TYPE == "bram") ? "block" : MEM_TYPE;

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_lane
    $error("ram_single_port: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (MEM_TYPE != "auto" && MEM_TYPE != "distributed" &&
      MEM_TYPE != "bram" && MEM_TYPE != "registers") begin : g_bad_type
    $error("ram_single_port: MEM_TYPE must be auto, distributed, bram or registers");
  end
  if (READ_LATENCY < 0 || READ_LATENCY > 4) begin : g_bad_lat
    $error("ram_single_port: READ_LATENCY must be in 0..4");
  end

  // Zero initialiser covers both simulation and the bitstream image.
  (* ram_style = RAM_STYLE *)
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic wr_en;
  assign wr_en = en && !reset;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (strobe[i]) mem[addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  if (READ_LATENCY == 0) begin : g_comb_rd
    assign rdata = mem[addr];
  end else begin : g_pipe_rd
    logic [DATA_WIDTH-1:0]                   rd_word;
    logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] pipe_q, pipe_d;

    always_comb begin
      rd_word = mem[addr];
`ifdef RAM_WRITE_FIRST_EN
      // Forward this edge's strobed lanes so stage 1 sees the new data.
      if (wr_en) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (strobe[i]) rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
`endif
    end

    always_comb begin
      pipe_d = pipe_q;
      if (reset) begin
        pipe_d = '0;
      end else if (en) begin
        pipe_d[0] = rd_word;
        for (int s = 1; s < READ_LATENCY; s++) pipe_d[s] = pipe_q[s-1];
      end
    end

    always_ff @(posedge clk) pipe_q <= pipe_d;

    assign rdata = pipe_q[READ_LATENCY-1];
  end

endmodule

// File: tb/tb_ram_single_port.sv
// Directed bench: four ram_single_port configurations on a shared clock and reset.
module tb_ram_single_port;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // u0: 64-bit word, single lane, latency 1
  logic        en0;   logic [9:0] addr0; logic [0:0] stb0; logic [63:0] wd0, rd0;
  // u1: 32-bit, byte lanes, latency 1
  logic        en1;   logic [3:0] addr1; logic [3:0] stb1; logic [31:0] wd1, rd1;
  // u2: 1-bit, combinational read
  logic        en2;   logic [3:0] addr2; logic [0:0] stb2; logic [0:0]  wd2, rd2;
  // u3: 32-bit, byte lanes, latency 2
  logic        en3;   logic [3:0] addr3; logic [3:0] stb3; logic [31:0] wd3, rd3;

  ram_single_port #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .BYTE_WIDTH(64), .MEM_TYPE("bram"),
                    .READ_LATENCY(1)) u0 (
    .clk(clk), .reset(reset), .en(en0), .addr(addr0), .strobe(stb0), .wdata(wd0), .rdata(rd0));
  ram_single_port #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .MEM_TYPE("distributed"),
                    .READ_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .en(en1), .addr(addr1), .strobe(stb1), .wdata(wd1), .rdata(rd1));
  ram_single_port #(.ADDR_WIDTH(4), .DATA_WIDTH(1), .BYTE_WIDTH(1), .MEM_TYPE("registers"),
                    .READ_LATENCY(0)) u2 (
    .clk(clk), .reset(reset), .en(en2), .addr(addr2), .strobe(stb2), .wdata(wd2), .rdata(rd2));
  ram_single_port #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .MEM_TYPE("auto"),
                    .READ_LATENCY(2)) u3 (
    .clk(clk), .reset(reset), .en(en3), .addr(addr3), .strobe(stb3), .wdata(wd3), .rdata(rd3));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] M1 = 32'h1111_0001;
  localparam logic [31:0] M2 = 32'h2222_0002;
  logic [31:0] rdw_exp;

  initial begin
    reset = 1'b1;
    en0 = 0; addr0 = '0; stb0 = '0; wd0 = '0;
    en1 = 0; addr1 = '0; stb1 = '0; wd1 = '0;
    en2 = 0; addr2 = '0; stb2 = '0; wd2 = '0;
    en3 = 0; addr3 = '0; stb3 = '0; wd3 = '0;
    tick(); tick();
    reset = 1'b0;

    chk("rst_u0", rd0, 64'h0);
    chk("rst_u1", rd1, 64'h0);
    chk("rst_u3", rd3, 64'h0);
    for (int a = 0; a < 16; a++) begin
      addr2 = a[3:0];
      #1;
      chk($sformatf("rst_u2_a%0d", a), rd2, 64'h0);
    end

    // 64-bit write then read back one edge later
    en0 = 1; addr0 = 10'd5; stb0 = 1'b1; wd0 = 64'hDEADBEEF_CAFEF00D;
    tick();
    stb0 = 1'b0; wd0 = '0;
    tick();
    chk("wr64_rd", rd0, 64'hDEADBEEF_CAFEF00D);
    en0 = 0;

    // full then partial strobe on consecutive cycles
    en1 = 1; addr1 = 4'd2; stb1 = 4'hF; wd1 = 32'h11223344;
    tick();
    stb1 = 4'b0101; wd1 = 32'hAABBCCDD;
    tick();
    stb1 = 4'h0;
    tick();
    chk("partial_strobe", rd1, 64'h11BB33DD);

    // read-during-write at addr 7
    addr1 = 4'd7; stb1 = 4'hF; wd1 = 32'hA;
    tick();
    wd1 = 32'hB;
    tick();
`ifdef RAM_WRITE_FIRST_EN
    rdw_exp = 32'hB;
`else
    rdw_exp = 32'hA;
`endif
    chk("rdw", rd1, {32'h0, rdw_exp});
    stb1 = 4'h0;
    tick();
    chk("rdw_after", rd1, 64'hB);

    // disabled write is ignored, pipeline holds
    en1 = 0; stb1 = 4'hF; wd1 = 32'hFF;
    tick();
    chk("en0_hold", rd1, 64'hB);
    en1 = 1; stb1 = 4'h0;
    tick();
    chk("en0_nowrite", rd1, 64'hB);
    en1 = 0;

    // combinational read, visible right after the writing edge
    en2 = 1; addr2 = 4'd3; stb2 = 1'b1; wd2 = 1'b1;
    tick();
    en2 = 0; stb2 = 1'b0; wd2 = 1'b0;
    #1;
    chk("lat0_a3", rd2, 64'h1);
    addr2 = 4'd4;
    #1;
    chk("lat0_a4", rd2, 64'h0);
    addr2 = 4'd3;
    #1;
    chk("lat0_en_indep", rd2, 64'h1);

    // latency 2: preload, read, stall, resume
    en3 = 1; stb3 = 4'hF; addr3 = 4'd1; wd3 = M1;
    tick();
    addr3 = 4'd2; wd3 = M2;
    tick();
    stb3 = 4'h0; wd3 = '0; addr3 = 4'd1;
    tick();
    addr3 = 4'd2;
    tick();
    chk("lat2_first", rd3, {32'h0, M1});
    en3 = 0; addr3 = 4'd0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("lat2_stall%0d", c), rd3, {32'h0, M1});
    end
    en3 = 1;
    tick();
    chk("lat2_resume", rd3, {32'h0, M2});
    tick();
    chk("lat2_drain", rd3, 64'h0);

    // reset mid-stream discards in-flight reads, keeps memory
    addr3 = 4'd1;
    tick();
    addr3 = 4'd2;
    tick();
    chk("pre_rst", rd3, {32'h0, M1});
    reset = 1'b1;
    tick();
    chk("mid_rst", rd3, 64'h0);
    chk("lat0_rst", rd2, 64'h1);
    reset = 1'b0; en3 = 0;
    tick();
    chk("post_rst_hold", rd3, 64'h0);
    en3 = 1; addr3 = 4'd1;
    tick();
    addr3 = 4'd2;
    tick();
    chk("mem_kept_m1", rd3, {32'h0, M1});
    addr3 = 4'd0;
    tick();
    chk("mem_kept_m2", rd3, {32'h0, M2});
    en3 = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
